// File: rtl/alut_mem_dp.sv
// alut_mem_dp: dual-port lookup-table RAM for the ALUT.
//   Port A serves the address checker and port B serves the age checker.
//   After reset, and on init_req, a hardware sweep writes INIT_VAL to every entry.
//   Each port has a ready/valid handshake. Read latency is RD_LAT (1 or 2).
//
// Ports:
//   pclk, p_reset        clock; asynchronous active-high reset
//   init_req, init_busy  start a clear sweep (RUN only) / sweep in progress
//   x_req, x_we          request strobe, write (1) / read (0)   (x = a, b)
//   x_addr, x_wdata      address and write data
//   x_ready              port can accept a request this cycle
//   x_rvalid, x_rdata    one-cycle return strobe; data holds until next return
//   collision            pulses the cycle after both ports wrote one address
//
// state  | meaning
// S_INIT | clear sweep: entry r_cnt <- INIT_VAL each cycle, ports not ready
// S_RUN  | normal operation, both ports ready
module alut_mem_dp #(
  parameter int             DW       = 83,
  parameter int             AW       = 8,
  parameter int             DD       = 256,
  parameter logic [DW-1:0]  INIT_VAL = '0,
  parameter int             RD_LAT   = 1,
  parameter int             BYPASS   = 1
) (
  input  logic          pclk,
  input  logic          p_reset,
  input  logic          init_req,
  output logic          init_busy,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ready,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ready,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          collision
);

  localparam int              IW      = (DD > 1) ? $clog2(DD) : 1;
  localparam logic [AW:0]     LP_DD   = (AW+1)'(DD);
  localparam logic [IW-1:0]   LP_LAST = IW'(DD - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_cnt, w_cnt_nxt;
  logic            w_sweep_we;
  logic            w_ready;

  logic [DW-1:0]   r_mem [DD];

  logic            w_a_acc, w_a_wr, w_a_rd, w_a_inr;
  logic            w_b_acc, w_b_wr, w_b_rd, w_b_inr;
  logic            w_same;
  logic [DW-1:0]   w_a_rd_data, w_b_rd_data;

  logic [1:0]      r_v1;
  logic [DW-1:0]   r_d1_a, r_d1_b;
  logic            r_coll;

  always_ff @(posedge pclk or posedge p_reset) begin
    if (p_reset) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sweep_we  = 1'b0;
    case (r_state)
      S_INIT: begin
        w_sweep_we = 1'b1;
        if (r_cnt == LP_LAST) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (init_req) begin
          w_state_nxt = S_INIT;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  assign w_ready   = (r_state == S_RUN);
  assign a_ready   = w_ready;
  assign b_ready   = w_ready;
  assign init_busy = ~w_ready;

  assign w_a_acc = a_req & w_ready;
  assign w_b_acc = b_req & w_ready;
  assign w_a_wr  = w_a_acc & a_we;
  assign w_b_wr  = w_b_acc & b_we;
  assign w_a_rd  = w_a_acc & ~a_we;
  assign w_b_rd  = w_b_acc & ~b_we;
  assign w_a_inr = ({1'b0, a_addr} < LP_DD);
  assign w_b_inr = ({1'b0, b_addr} < LP_DD);
  assign w_same  = (a_addr == b_addr);

  // Out-of-range reads return INIT_VAL; a read colliding with the other
  // port's write sees that write data only when BYPASS is set.
  assign w_a_rd_data = !w_a_inr                          ? INIT_VAL :
                       (BYPASS != 0 && w_b_wr && w_same) ? b_wdata  :
                       r_mem[a_addr[IW-1:0]];
  assign w_b_rd_data = !w_b_inr                          ? INIT_VAL :
                       (BYPASS != 0 && w_a_wr && w_same) ? a_wdata  :
                       r_mem[b_addr[IW-1:0]];

  // Port A wins a same-address double write, so B is suppressed there.
  always_ff @(posedge pclk) begin
    if (w_sweep_we) begin
      r_mem[r_cnt] <= INIT_VAL;
    end else begin
      if (w_b_wr && w_b_inr && !(w_a_wr && w_same))
        r_mem[b_addr[IW-1:0]] <= b_wdata;
      if (w_a_wr && w_a_inr)
        r_mem[a_addr[IW-1:0]] <= a_wdata;
    end
  end

  always_ff @(posedge pclk or posedge p_reset) begin
    if (p_reset) begin
      r_v1   <= '0;
      r_d1_a <= '0;
      r_d1_b <= '0;
      r_coll <= 1'b0;
    end else begin
      r_v1   <= {w_b_rd, w_a_rd};
      r_coll <= w_a_wr & w_b_wr & w_same & w_a_inr;
      if (w_a_rd) r_d1_a <= w_a_rd_data;
      if (w_b_rd) r_d1_b <= w_b_rd_data;
    end
  end

  assign collision = r_coll;

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [1:0]    r_v2;
      logic [DW-1:0] r_d2_a, r_d2_b;

      always_ff @(posedge pclk or posedge p_reset) begin
        if (p_reset) begin
          r_v2   <= '0;
          r_d2_a <= '0;
          r_d2_b <= '0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1[0]) r_d2_a <= r_d1_a;
          if (r_v1[1]) r_d2_b <= r_d1_b;
        end
      end

      assign a_rvalid = r_v2[0];
      assign b_rvalid = r_v2[1];
      assign a_rdata  = r_d2_a;
      assign b_rdata  = r_d2_b;
    end else begin : g_lat1
      assign a_rvalid = r_v1[0];
      assign b_rvalid = r_v1[1];
      assign a_rdata  = r_d1_a;
      assign b_rdata  = r_d1_b;
    end
  endgenerate

endmodule

// File: tb/tb_alut_mem_dp.sv
// Bench for alut_mem_dp. Two instances share stimulus:
//   dut 0: AW=8, RD_LAT=1, BYPASS=1 (sees the low 8 address bits)
//   dut 1: AW=9, RD_LAT=2, BYPASS=0 (sees all 9 bits, so 256..511 are out of range)
module tb_alut_mem_dp;
  localparam int DW = 83;

  logic pclk = 1'b0;
  logic p_reset = 1'b1;
  logic init_req = 1'b0;
  logic req [2];
  logic we [2];
  logic [8:0] addr [2];
  logic [DW-1:0] wdata [2];

  logic o_busy [2];
  logic o_coll [2];
  logic o_ready [2][2];
  logic o_rvalid [2][2];
  logic [DW-1:0] o_rdata [2][2];

  int checks = 0;
  int failures = 0;

  always #5 pclk = ~pclk;

  alut_mem_dp #(.DW(DW), .AW(8), .DD(256), .RD_LAT(1), .BYPASS(1)) u_dut0 (
    .pclk(pclk), .p_reset(p_reset), .init_req(init_req), .init_busy(o_busy[0]),
    .a_req(req[0]), .a_we(we[0]), .a_addr(addr[0][7:0]), .a_wdata(wdata[0]),
    .a_ready(o_ready[0][0]), .a_rvalid(o_rvalid[0][0]), .a_rdata(o_rdata[0][0]),
    .b_req(req[1]), .b_we(we[1]), .b_addr(addr[1][7:0]), .b_wdata(wdata[1]),
    .b_ready(o_ready[0][1]), .b_rvalid(o_rvalid[0][1]), .b_rdata(o_rdata[0][1]),
    .collision(o_coll[0]));

  alut_mem_dp #(.DW(DW), .AW(9), .DD(256), .RD_LAT(2), .BYPASS(0)) u_dut1 (
    .pclk(pclk), .p_reset(p_reset), .init_req(init_req), .init_busy(o_busy[1]),
    .a_req(req[0]), .a_we(we[0]), .a_addr(addr[0]), .a_wdata(wdata[0]),
    .a_ready(o_ready[1][0]), .a_rvalid(o_rvalid[1][0]), .a_rdata(o_rdata[1][0]),
    .b_req(req[1]), .b_we(we[1]), .b_addr(addr[1]), .b_wdata(wdata[1]),
    .b_ready(o_ready[1][1]), .b_rvalid(o_rvalid[1][1]), .b_rdata(o_rdata[1][1]),
    .collision(o_coll[1]));

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%b required=%b", nm, $time, act, exp);
    end
  endtask

  task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Memory as a plain array, sweep as a count of remaining busy edges (the
  // array is cleared wholesale when a sweep starts), returns scheduled by
  // edge number.
  logic [DW-1:0] mm [2][512];
  int            busy [2];
  bit            ecoll [2];
  bit            sv [2][2][8];
  logic [DW-1:0] sd [2][2][8];
  logic [DW-1:0] last [2][2];
  int            edges = 0;

  function automatic int ea(int m, logic [8:0] a);
    return (m == 0) ? int'(a[7:0]) : int'(a);
  endfunction

  task automatic model_reset(int m);
    busy[m] = 256;
    ecoll[m] = 1'b0;
    for (int a = 0; a < 512; a++) mm[m][a] = '0;
    for (int p = 0; p < 2; p++) begin
      last[m][p] = '0;
      for (int k = 0; k < 8; k++) sv[m][p][k] = 1'b0;
    end
  endtask

  task automatic model_step(int m);
    int ap [2];
    bit wr [2];
    bit rd [2];
    logic [DW-1:0] d;
    int slot;
    for (int p = 0; p < 2; p++) begin
      ap[p] = ea(m, addr[p]);
      wr[p] = req[p] && we[p];
      rd[p] = req[p] && !we[p];
    end
    for (int p = 0; p < 2; p++) begin
      if (rd[p]) begin
        if (ap[p] >= 256) d = '0;
        else if (m == 0 && wr[1-p] && ap[1-p] == ap[p]) d = wdata[1-p];
        else d = mm[m][ap[p]];
        slot = (edges + m) % 8;
        sv[m][p][slot] = 1'b1;
        sd[m][p][slot] = d;
      end
    end
    if (wr[1] && ap[1] < 256) mm[m][ap[1]] = wdata[1];
    if (wr[0] && ap[0] < 256) mm[m][ap[0]] = wdata[0];
    ecoll[m] = wr[0] && wr[1] && ap[0] == ap[1] && ap[0] < 256;
    if (init_req) begin
      busy[m] = 256;
      for (int a = 0; a < 512; a++) mm[m][a] = '0;
    end
  endtask

  // Check outputs after the last edge, then advance the model through the
  // next edge using the inputs that edge will sample.
  always @(negedge pclk) begin : mon
    int slot;
    bit v;
    for (int m = 0; m < 2; m++) begin
      if (p_reset) begin
        chk1("rst_init_busy", o_busy[m], 1'b1);
        chk1("rst_collision", o_coll[m], 1'b0);
        for (int p = 0; p < 2; p++) begin
          chk1("rst_ready", o_ready[m][p], 1'b0);
          chk1("rst_rvalid", o_rvalid[m][p], 1'b0);
          chkd("rst_rdata", o_rdata[m][p], '0);
        end
      end else begin
        chk1("init_busy", o_busy[m], busy[m] != 0);
        chk1("collision", o_coll[m], ecoll[m]);
        slot = edges % 8;
        for (int p = 0; p < 2; p++) begin
          chk1("ready", o_ready[m][p], busy[m] == 0);
          v = sv[m][p][slot];
          if (v) begin
            last[m][p] = sd[m][p][slot];
            sv[m][p][slot] = 1'b0;
          end
          chk1("rvalid", o_rvalid[m][p], v);
          chkd("rdata", o_rdata[m][p], last[m][p]);
        end
      end
    end
    edges++;
    for (int m = 0; m < 2; m++) begin
      if (p_reset) model_reset(m);
      else if (busy[m] > 0) begin
        busy[m]--;
        ecoll[m] = 1'b0;
      end else model_step(m);
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    int            p;
    bit            w;
    logic [8:0]    a;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl [11];

  task automatic tick();
    @(posedge pclk);
    #2;
  endtask

  task automatic idle();
    for (int p = 0; p < 2; p++) req[p] = 1'b0;
    init_req = 1'b0;
  endtask

  task automatic drive(int p, bit w, logic [8:0] a, logic [DW-1:0] wd);
    req[p] = 1'b1;
    we[p] = w;
    addr[p] = a;
    wdata[p] = wd;
  endtask

  task automatic count_sweep(input string nm);
    int n;
    n = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge pclk);
      n++;
      #1;
      if (o_ready[0][0]) break;
    end
    chk1({nm, "_ready_dut0"}, o_ready[0][0], 1'b1);
    chk1({nm, "_ready_dut1"}, o_ready[1][1], 1'b1);
    chk1({nm, "_busy_fell"}, o_busy[0], 1'b0);
    chkd({nm, "_edges"}, DW'(n), DW'(256));
    #1;
  endtask

  initial begin
    logic [95:0] r96;
    int n;
    idle();
    for (int p = 0; p < 2; p++) begin
      we[p] = 1'b0;
      addr[p] = '0;
      wdata[p] = '0;
    end

    tbl[0]  = '{0, 1'b0, 9'd0,   83'h0,     83'h0};
    tbl[1]  = '{0, 1'b1, 9'd5,   83'h12345, 83'h0};
    tbl[2]  = '{0, 1'b0, 9'd5,   83'h0,     83'h12345};
    tbl[3]  = '{1, 1'b1, 9'd20,  83'hABC,   83'h0};
    tbl[4]  = '{0, 1'b0, 9'd20,  83'h0,     83'hABC};
    tbl[5]  = '{1, 1'b0, 9'd5,   83'h0,     83'h12345};
    tbl[6]  = '{1, 1'b1, 9'd255, 83'h7FFFFFFFFFFFFFFFFFFFF, 83'h0};
    tbl[7]  = '{0, 1'b0, 9'd255, 83'h0,     83'h7FFFFFFFFFFFFFFFFFFFF};
    tbl[8]  = '{1, 1'b0, 9'd200, 83'h0,     83'h0};
    tbl[9]  = '{0, 1'b1, 9'd5,   83'h0,     83'h0};
    tbl[10] = '{1, 1'b0, 9'd5,   83'h0,     83'h0};

    repeat (3) tick();
    p_reset = 1'b0;
    count_sweep("post_reset");

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].p, tbl[i].w, tbl[i].a, tbl[i].wd);
      tick();
      idle();
      repeat (3) tick();
      if (!tbl[i].w)
        for (int m = 0; m < 2; m++) chkd("table_rdata", o_rdata[m][tbl[i].p], tbl[i].exp);
    end

    // read latency: write 5 then read it on the next cycle
    drive(0, 1'b1, 9'd5, 83'h12345);
    tick();
    drive(0, 1'b0, 9'd5, 83'h0);
    tick();
    idle();
    @(negedge pclk);
    chk1("lat1_rvalid", o_rvalid[0][0], 1'b1);
    chkd("lat1_rdata", o_rdata[0][0], 83'h12345);
    chk1("lat2_not_yet", o_rvalid[1][0], 1'b0);
    @(negedge pclk);
    chk1("lat2_rvalid", o_rvalid[1][0], 1'b1);
    chkd("lat2_rdata", o_rdata[1][0], 83'h12345);
    chk1("lat1_one_pulse", o_rvalid[0][0], 1'b0);
    tick();

    // double write to one address
    drive(0, 1'b1, 9'd7, 83'hAA);
    drive(1, 1'b1, 9'd7, 83'hBB);
    tick();
    idle();
    @(negedge pclk);
    chk1("coll_dut0", o_coll[0], 1'b1);
    chk1("coll_dut1", o_coll[1], 1'b1);
    tick();
    drive(1, 1'b0, 9'd7, 83'h0);
    tick();
    idle();
    repeat (3) tick();
    chkd("coll_a_wins_dut0", o_rdata[0][1], 83'hAA);
    chkd("coll_a_wins_dut1", o_rdata[1][1], 83'hAA);

    // read against write on the same address
    drive(0, 1'b1, 9'd9, 83'h11);
    tick();
    drive(0, 1'b0, 9'd9, 83'h0);
    drive(1, 1'b1, 9'd9, 83'h22);
    tick();
    idle();
    @(negedge pclk);
    chk1("rw_no_coll_dut0", o_coll[0], 1'b0);
    chk1("rw_no_coll_dut1", o_coll[1], 1'b0);
    repeat (3) tick();
    chkd("bypass_on", o_rdata[0][0], 83'h22);
    chkd("bypass_off", o_rdata[1][0], 83'h11);

    // sweep started while a read is in flight
    drive(0, 1'b1, 9'd3, 83'h33);
    tick();
    drive(0, 1'b0, 9'd3, 83'h0);
    tick();
    idle();
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    @(negedge pclk);
    chkd("inflight_dut0", o_rdata[0][0], 83'h33);
    chkd("inflight_dut1", o_rdata[1][0], 83'h33);
    chk1("sweep_ready_low", o_ready[0][0], 1'b0);
    n = 1;
    for (int i = 0; i < 600; i++) begin
      @(negedge pclk);
      if (o_ready[0][0]) break;
      n++;
    end
    chkd("sweep_low_cycles", DW'(n), DW'(256));
    tick();
    drive(0, 1'b0, 9'd3, 83'h0);
    tick();
    idle();
    repeat (3) tick();
    chkd("cleared_dut0", o_rdata[0][0], 83'h0);
    chkd("cleared_dut1", o_rdata[1][0], 83'h0);

    // reset in the middle of a sweep, at entry 100
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    repeat (100) tick();
    p_reset = 1'b1;
    repeat (3) tick();
    p_reset = 1'b0;
    count_sweep("mid_reset");

    // out-of-range address on the AW=9 instance
    drive(0, 1'b1, 9'd300, 83'h5555);
    tick();
    drive(0, 1'b0, 9'd300, 83'h0);
    tick();
    idle();
    repeat (3) tick();
    chkd("oor_read_dut1", o_rdata[1][0], 83'h0);

    // random traffic; the monitor compares everything against the model
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        req[p] = 1'($urandom_range(0, 1));
        we[p] = 1'($urandom_range(0, 1));
        addr[p] = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511))
                                              : 9'($urandom_range(0, 7));
        r96 = {$urandom(), $urandom(), $urandom()};
        wdata[p] = r96[DW-1:0];
      end
      init_req = ($urandom_range(0, 399) == 0);
      tick();
    end
    idle();
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
